uart_tx_cfg: RTL and testbench

Parametrised UART transmitter with a runtime-configurable frame format: parity none/even/odd/mark, and 1 or 2 stop bits. Words are buffered in an internal FIFO of depth FIFO_DEPTH, then prefetched into a holding register so consecutive frames go out with no idle gap. The whole block runs on one clock, clk_i, and bit timing comes from a one-cycle baud_tick_i strobe supplied by the shared baud generator. Sits between the bus-side register interface and the tx pin.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_tx_cfg_if.sv | 22 ++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_tx_cfg.sv | 138 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, transmitter FSM states and the per-frame configuration.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  typedef struct packed {
    parity_e parity;
    logic    stop2;
  } frame_cfg_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Parity bit from the XOR of the data bits.
  function automatic logic parity_bit(parity_e mode, logic data_xor);
    case (mode)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Bus-side interface of the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              wr;
  logic [DATA_W-1:0] data;
  logic [1:0]        parity;
  logic              stop2;
  logic              rdy;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [LVL_W-1:0]  fifo_level;

  modport master (output wr, data, parity, stop2,
                  input  rdy, busy, done, overflow, fifo_level);
  modport slave  (input  wr, data, parity, stop2,
                  output rdy, busy, done, overflow, fifo_level);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; a pop takes effect on the next clock.
module uart_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              wr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              rd,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH):0]       level
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic              push, pop;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push    = wr & ~full;
  assign pop     = rd & ~empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime parity/stop format, FIFO buffering and a prefetch
// holding register so queued frames go out back-to-back.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         baud_tick_i,
  output logic         tx_o,
  uart_tx_cfg_if.slave bus
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  tx_state_e         state, state_nx;
  frame_cfg_t        cfg;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data, shifter, fifo_data;
  logic [CNT_W-1:0]  bit_cnt;
  logic              par_bit, last_bit;
  logic              fifo_full, fifo_empty, pop;
  logic [LVL_W-1:0]  level;
  logic              tx_nx, done_nx, load, shift, frame_end;

  assign pop      = ~hold_valid & ~fifo_empty;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr      (bus.wr),
    .wr_data (bus.data),
    .rd      (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign bus.rdy        = ~fifo_full;
  assign bus.fifo_level = level;
  assign bus.busy       = (state != IDLE) | hold_valid | (level != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (baud_tick_i) begin
      unique case (state)
        IDLE:    if (hold_valid) state_nx = START;
        START:   state_nx = DATA;
        DATA:    if (last_bit) state_nx = (cfg.parity != PAR_NONE) ? PARITY : STOP1;
        PARITY:  state_nx = STOP1;
        STOP1:   state_nx = cfg.stop2 ? STOP2 : (hold_valid ? START : IDLE);
        STOP2:   state_nx = hold_valid ? START : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next line level, shifter control and frame-end handling; a waiting word starts
  // on the same tick that ends the previous frame.
  always_comb begin
    tx_nx     = tx_o;
    done_nx   = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
    if (baud_tick_i) begin
      case (state)
        IDLE: if (hold_valid) begin
          load  = 1'b1;
          tx_nx = ~IDLE_LEVEL;
        end
        START: begin
          tx_nx = shifter[0];
          shift = 1'b1;
        end
        DATA: if (last_bit) begin
          tx_nx = (cfg.parity != PAR_NONE) ? par_bit : IDLE_LEVEL;
        end else begin
          tx_nx = shifter[0];
          shift = 1'b1;
        end
        PARITY:  tx_nx = IDLE_LEVEL;
        STOP1:   if (cfg.stop2) tx_nx = IDLE_LEVEL; else frame_end = 1'b1;
        STOP2:   frame_end = 1'b1;
        default: tx_nx = IDLE_LEVEL;
      endcase
    end
    if (frame_end) begin
      done_nx = 1'b1;
      if (hold_valid) begin
        load  = 1'b1;
        tx_nx = ~IDLE_LEVEL;
      end else begin
        tx_nx = IDLE_LEVEL;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_o         <= IDLE_LEVEL;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      shifter      <= '0;
      bit_cnt      <= '0;
      par_bit      <= 1'b0;
      cfg          <= '{parity: PAR_NONE, stop2: 1'b0};
    end else begin
      tx_o         <= tx_nx;
      bus.done     <= done_nx;
      bus.overflow <= bus.wr & fifo_full;
      if (load)     hold_valid <= 1'b0;
      else if (pop) hold_valid <= 1'b1;
      if (pop) hold_data <= fifo_data;
      if (load) begin
        shifter <= hold_data;
        bit_cnt <= '0;
        cfg     <= '{parity: parity_e'(bus.parity), stop2: bus.stop2};
        par_bit <= parity_bit(parity_e'(bus.parity), ^hold_data);
      end else if (shift) begin
        shifter <= shifter >> 1;
        if (state == DATA) bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: decodes the serial line per baud tick and
// compares frames against a protocol-level reference.
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic tx;

  uart_tx_cfg_if #(.DATA_W(8), .FIFO_DEPTH(16)) bus ();

  uart_tx_cfg #(.DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_tick_i (tick),
    .tx_o        (tx),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  tick_period = 16;
  bit  tick_en = 1'b1;
  int  tcnt = 0;
  bit  tick_seen;
  bit  line_q[$];
  int  done_q[$];

  initial begin
    forever begin
      @(posedge clk); #1;
      tcnt++;
      if (tick_en && tcnt >= tick_period) begin tick = 1'b1; tcnt = 0; end
      else tick = 1'b0;
    end
  end

  // Line level during each bit interval, and the interval index at which done pulses.
  always @(posedge clk) tick_seen <= tick;
  always @(negedge clk) begin
    if (tick_seen) line_q.push_back(tx);
    if (bus.done) done_q.push_back(line_q.size() - 1);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    bus.data = w;
    bus.wr   = 1'b1;
    @(posedge clk); #1;
    bus.wr   = 1'b0;
  endtask

  task automatic clear_mon();
    line_q.delete();
    done_q.delete();
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int c = 0;
    while (done_q.size() < n && c < budget) begin @(negedge clk); c++; end
    if (done_q.size() < n) begin
      checks++; failures++;
      $display("FAIL %s timeout: done pulses %0d expected %0d", nm, done_q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  function automatic int frame_len(input logic [1:0] par, input bit st2);
    return 1 + 8 + ((par != 2'b00) ? 1 : 0) + (st2 ? 2 : 1);
  endfunction

  // Expected bit sequence of one frame, first bit on the line in bit 0.
  function automatic logic [31:0] ref_frame(input logic [7:0] w, input logic [1:0] par, input bit st2);
    bit b[$];
    logic [31:0] v = '0;
    int ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin b.push_back(w[i]); ones += int'(w[i]); end
    if (par == 2'b01) b.push_back(ones % 2 == 1);
    if (par == 2'b10) b.push_back(ones % 2 == 0);
    if (par == 2'b11) b.push_back(1'b1);
    b.push_back(1'b1);
    if (st2) b.push_back(1'b1);
    foreach (b[i]) v[i] = b[i];
    return v;
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < line_q.size(); i++) if (line_q[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic check_frame(input string nm, input int from, input logic [7:0] w,
                             input logic [1:0] par, input bit st2, output int s, output int e);
    int len;
    logic [31:0] v;
    len = frame_len(par, st2);
    e = -1;
    s = find_start(from);
    if (s < 0) begin
      checks++; failures++;
      $display("FAIL %s: no start bit on line, got none expected one", nm);
      return;
    end
    v = '0;
    for (int i = 0; i < len; i++) v[i] = (s + i < line_q.size()) ? line_q[s+i] : 1'bx;
    chk({nm, " bits"}, v, ref_frame(w, par, st2));
    foreach (done_q[k]) if (e < 0 && done_q[k] > s) e = done_q[k];
    chk({nm, " len"}, 32'(e - s), 32'(len));
  endtask

  typedef struct {
    logic [7:0] w;
    logic [1:0] par;
    bit         st2;
    int         len;
    logic       pbit;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int s, e, s1, e1, c;
    logic [7:0] words[6];
    logic [1:0] par;
    bit st2;
    int n;

    bus.wr = 1'b0; bus.data = '0; bus.parity = 2'b00; bus.stop2 = 1'b0;

    tbl[0] = '{8'h55, 2'd0, 1'b0, 10, 1'b0};
    tbl[1] = '{8'h55, 2'd1, 1'b0, 11, 1'b0};
    tbl[2] = '{8'h55, 2'd2, 1'b0, 11, 1'b1};
    tbl[3] = '{8'h00, 2'd3, 1'b0, 11, 1'b1};
    tbl[4] = '{8'hA3, 2'd0, 1'b1, 11, 1'b0};
    tbl[5] = '{8'h0F, 2'd2, 1'b1, 12, 1'b1};
    tbl[6] = '{8'hFF, 2'd1, 1'b1, 12, 1'b0};
    tbl[7] = '{8'h01, 2'd1, 1'b0, 11, 1'b1};
    tbl[8] = '{8'h80, 2'd2, 1'b0, 11, 1'b0};

    step(3);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset rdy", 32'(bus.rdy), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset overflow", 32'(bus.overflow), 32'd0);
    chk("reset level", 32'(bus.fifo_level), 32'd0);
    rst = 1'b0;
    step(2);

    // Single frames over all parity/stop formats.
    tick_period = 16;
    foreach (tbl[i]) begin
      clear_mon();
      bus.parity = tbl[i].par;
      bus.stop2  = tbl[i].st2;
      push(tbl[i].w);
      wait_done(1, 400, $sformatf("tbl%0d", i));
      step(2);
      check_frame($sformatf("tbl%0d", i), 0, tbl[i].w, tbl[i].par, tbl[i].st2, s, e);
      chk($sformatf("tbl%0d table len", i), 32'(e - s), 32'(tbl[i].len));
      if (tbl[i].par != 2'b00)
        chk($sformatf("tbl%0d parity bit", i), 32'(line_q[s+9]), 32'(tbl[i].pbit));
      chk($sformatf("tbl%0d busy after", i), 32'(bus.busy), 32'd0);
      chk($sformatf("tbl%0d done count", i), 32'(done_q.size()), 32'd1);
    end

    // Back-to-back frames with two stop bits: no idle bit between them.
    clear_mon();
    bus.parity = 2'b00; bus.stop2 = 1'b1;
    push(8'hA3);
    push(8'h0F);
    wait_done(2, 800, "b2b");
    step(2);
    check_frame("b2b f1", 0, 8'hA3, 2'b00, 1'b1, s1, e1);
    check_frame("b2b f2", e1, 8'h0F, 2'b00, 1'b1, s, e);
    chk("b2b gap", 32'(s), 32'(e1));
    chk("b2b total ticks", 32'(e - s1), 32'd22);

    // Mid-frame parity change only affects the next frame.
    clear_mon();
    tick_period = 8;
    bus.parity = 2'b00; bus.stop2 = 1'b0;
    push(8'h96);
    push(8'h96);
    c = 0;
    do begin @(negedge clk); c++; s = find_start(0); end
    while (!(s >= 0 && line_q.size() > s + 3) && c < 2000);
    @(posedge clk); #1;
    bus.parity = 2'b01;
    wait_done(2, 600, "midcfg");
    step(2);
    check_frame("midcfg f1", 0, 8'h96, 2'b00, 1'b0, s1, e1);
    check_frame("midcfg f2", e1, 8'h96, 2'b01, 1'b0, s, e);
    chk("midcfg gap", 32'(s), 32'(e1));

    // Randomized bursts against the reference frame model.
    for (int b = 0; b < 8; b++) begin
      clear_mon();
      tick_period = $urandom_range(2, 6);
      par = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      bus.parity = par; bus.stop2 = st2;
      for (int k = 0; k < n; k++) begin words[k] = 8'($urandom); push(words[k]); end
      wait_done(n, n * 13 * tick_period + 100, $sformatf("rnd%0d", b));
      step(2);
      e1 = 0;
      for (int k = 0; k < n; k++) begin
        check_frame($sformatf("rnd%0d f%0d", b, k), e1, words[k], par, st2, s, e);
        if (k > 0) chk($sformatf("rnd%0d gap%0d", b, k), 32'(s), 32'(e1));
        e1 = (e < 0) ? 0 : e;
      end
      chk($sformatf("rnd%0d done count", b), 32'(done_q.size()), 32'(n));
      chk($sformatf("rnd%0d busy after", b), 32'(bus.busy), 32'd0);
    end

    // FIFO fill and overflow with the baud ticks stopped.
    tick_en = 1'b0;
    step(2);
    clear_mon();
    bus.parity = 2'b00; bus.stop2 = 1'b0;
    for (int k = 0; k < 17; k++) push(8'h00);
    chk("fill level", 32'(bus.fifo_level), 32'd16);
    chk("fill rdy", 32'(bus.rdy), 32'd0);
    chk("fill no overflow", 32'(bus.overflow), 32'd0);
    push(8'h00);
    chk("overflow pulse", 32'(bus.overflow), 32'd1);
    chk("overflow level", 32'(bus.fifo_level), 32'd16);
    step(1);
    chk("overflow one clk", 32'(bus.overflow), 32'd0);
    chk("overflow level hold", 32'(bus.fifo_level), 32'd16);

    // Reset during data bit 4 of a zero word.
    tick_period = 4;
    tick_en = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; s = find_start(0); end
    while (!(s >= 0 && line_q.size() > s + 5) && c < 2000);
    chk("pre-reset tx low", 32'(tx), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async reset tx", 32'(tx), 32'd1);
    chk("async reset level", 32'(bus.fifo_level), 32'd0);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    chk("async reset rdy", 32'(bus.rdy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    step(2);
    bus.parity = 2'b01; bus.stop2 = 1'b0;
    push(8'h3C);
    wait_done(1, 200, "post-reset");
    step(120);
    check_frame("post-reset", 0, 8'h3C, 2'b01, 1'b0, s, e);
    chk("post-reset done count", 32'(done_q.size()), 32'd1);
    chk("post-reset busy", 32'(bus.busy), 32'd0);
    chk("post-reset idle tx", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
